popcount_neuron_sched: RTL and testbench

- Sequencer for one ternary neuron built on a single shared 24-input popcount unit (exact or approximate popcount24 variant), instantiated outside this block.
- Streams CHUNKS 24-bit activation chunks with positive/negative weight masks.
- Time-multiplexes the popcount between the positive and negative partial sums and accumulates each.
- Applies signed thresholds to produce a ternary activation {-1, 0, +1} through a valid/ready output.

---
 rtl/popcount_neuron_sched.sv | 160 ++++++++++++++++
 tb/tb_popcount_neuron_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/popcount_neuron_sched.sv
// popcount_neuron_sched: ternary neuron sequencer time-sharing one external 24-input popcount.
// Build macro NSCHED_ZERO_SKIP_EN skips the negative pass of a chunk whose x&wn is zero.
module popcount_neuron_sched #(
  parameter int CHUNKS = 4,
  parameter int ACC_W  = 7,
  parameter int CNT_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [23:0]             in_x,
  input  logic [23:0]             in_wp,
  input  logic [23:0]             in_wn,
  input  logic signed [ACC_W:0]   thr_hi,
  input  logic signed [ACC_W:0]   thr_lo,
  output logic [23:0]             pc_in,
  input  logic [4:0]              pc_cnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_y,
  output logic signed [ACC_W:0]   out_diff
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_POS  = 2'd1,
    S_NEG  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [23:0]            x_r, wp_r, wn_r;
  logic signed [ACC_W:0]  thr_hi_r, thr_lo_r;
  logic [ACC_W-1:0]       acc_p_r, acc_n_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [ACC_W-1:0]       add_s, acc_p_nxt_s, acc_n_nxt_s;
  logic signed [ACC_W:0]  diff_nxt_s;
  logic                   last_s, skip_s;

  // Approximate popcount units may report more than 24 set bits.
  function automatic logic [4:0] clamp24(input logic [4:0] c);
    if (c > 5'd24) begin
      return 5'd24;
    end else begin
      return c;
    end
  endfunction

  function automatic logic [1:0] ternary(input logic signed [ACC_W:0] d,
                                         input logic signed [ACC_W:0] hi,
                                         input logic signed [ACC_W:0] lo);
    if (d >= hi) begin
      return 2'b01;
    end else if (d <= lo) begin
      return 2'b11;
    end else begin
      return 2'b00;
    end
  endfunction

  assign add_s  = ACC_W'(clamp24(pc_cnt));
  assign last_s = (cnt_r == CNT_W'(CHUNKS - 1));
`ifdef NSCHED_ZERO_SKIP_EN
  assign skip_s = ((x_r & wn_r) == 24'd0);
`else
  assign skip_s = 1'b0;
`endif

  // Handshake and popcount operand select, purely from the current state.
  always_comb begin
    in_ready = 1'b0;
    pc_in    = 24'd0;
    case (state_r)
      S_LOAD:  in_ready = 1'b1;
      S_POS:   pc_in = x_r & wp_r;
      S_NEG:   pc_in = x_r & wn_r;
      default: pc_in = 24'd0;
    endcase
  end

  // Next accumulator values; the final diff must include this cycle's popcount.
  always_comb begin
    acc_p_nxt_s = acc_p_r;
    acc_n_nxt_s = acc_n_r;
    if (state_r == S_POS) begin
      acc_p_nxt_s = acc_p_r + add_s;
    end else if (state_r == S_NEG) begin
      acc_n_nxt_s = acc_n_r + add_s;
    end else begin
      acc_p_nxt_s = acc_p_r;
    end
    diff_nxt_s = $signed({1'b0, acc_p_nxt_s}) - $signed({1'b0, acc_n_nxt_s});
  end

  // Sequencer FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_LOAD;
      x_r       <= 24'd0;
      wp_r      <= 24'd0;
      wn_r      <= 24'd0;
      thr_hi_r  <= '0;
      thr_lo_r  <= '0;
      acc_p_r   <= '0;
      acc_n_r   <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      out_y     <= 2'b00;
      out_diff  <= '0;
    end else begin
      case (state_r)
        S_LOAD: begin
          if (in_valid) begin
            x_r     <= in_x;
            wp_r    <= in_wp;
            wn_r    <= in_wn;
            if (cnt_r == '0) begin
              thr_hi_r <= thr_hi;
              thr_lo_r <= thr_lo;
            end else begin
              thr_hi_r <= thr_hi_r;
            end
            state_r <= S_POS;
          end else begin
            state_r <= S_LOAD;
          end
        end
        S_POS, S_NEG: begin
          acc_p_r <= acc_p_nxt_s;
          acc_n_r <= acc_n_nxt_s;
          if ((state_r == S_POS) && !skip_s) begin
            state_r <= S_NEG;
          end else if (last_s) begin
            cnt_r     <= '0;
            state_r   <= S_OUT;
            out_valid <= 1'b1;
            out_diff  <= diff_nxt_s;
            out_y     <= ternary(diff_nxt_s, thr_hi_r, thr_lo_r);
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= S_LOAD;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_p_r   <= '0;
            acc_n_r   <= '0;
            state_r   <= S_LOAD;
          end else begin
            state_r <= S_OUT;
          end
        end
        default: state_r <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_neuron_sched.sv
// Self-checking bench for popcount_neuron_sched: directed vector table, reset abort, randomized evaluations.
module tb_popcount_neuron_sched;
  localparam int CH    = 4;
  localparam int ACC_W = 7;
  localparam int CNT_W = 3;
`ifdef NSCHED_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int LAT_W0 = SKIP ? 8 : 12;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [23:0] in_x = 24'd0, in_wp = 24'd0, in_wn = 24'd0, pc_in;
  logic signed [ACC_W:0] thr_hi = '0, thr_lo = '0, out_diff;
  logic [4:0] pc_cnt;
  logic [1:0] out_y;

  int checks = 0, errors = 0, cyc = 0;
  bit f31 = 1'b0, pos_phase = 1'b0;
  logic [23:0] cx [CH], cwp [CH], cwn [CH];

  typedef struct {
    logic [23:0] x, wp, wn;
    int hi, lo;
    bit f31;
    int diff;
    logic [1:0] y;
    int lat;
  } vec_t;
  vec_t vt [7];

  popcount_neuron_sched #(.CHUNKS(CH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_wp(in_wp), .in_wn(in_wn), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .pc_in(pc_in), .pc_cnt(pc_cnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_diff(out_diff)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // The cycle right after an accepted chunk is the positive popcount phase.
  always @(posedge clk) pos_phase <= in_valid && in_ready;
  assign pc_cnt = (f31 && pos_phase) ? 5'd31 : 5'($countones(pc_in));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(input int hi, input int lo, output int diff, output logic [1:0] y);
    int p, n;
    p = 0;
    n = 0;
    for (int k = 0; k < CH; k++) begin
      p += f31 ? 24 : $countones(cx[k] & cwp[k]);
      n += $countones(cx[k] & cwn[k]);
    end
    diff = p - n;
    y = (diff >= hi) ? 2'b01 : ((diff <= lo) ? 2'b11 : 2'b00);
  endtask

  // Entered and left at a negedge. exp_lat < 0 disables the latency check.
  task automatic run_eval(input int hi, input int lo, input bit gaps, input int abort_chunk,
                          input int hold, input int exp_diff, input logic [1:0] exp_y, input int exp_lat);
    int c0, t;
    bit skip_k;
    c0 = 0;
    for (int k = 0; k < CH; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_x = cx[k];
      in_wp = cwp[k];
      in_wn = cwn[k];
      thr_hi = (k == 0) ? 8'(hi) : 8'($urandom);
      thr_lo = (k == 0) ? 8'(lo) : 8'($urandom);
      if (k == 0) c0 = cyc;
      @(negedge clk);
      chk("pc_in_pos", pc_in, cx[k] & cwp[k]);
      in_x = 24'($urandom);
      in_wp = 24'($urandom);
      in_wn = 24'($urandom);
      skip_k = SKIP && ((cx[k] & cwn[k]) == 24'd0);
      if (!skip_k) begin
        @(negedge clk);
        chk("pc_in_neg", pc_in, cx[k] & cwn[k]);
        if (k == abort_chunk) begin
          rst_n = 1'b0;
          in_valid = 1'b0;
          #1;
          chk("abort_out_valid", out_valid, 0);
          chk("abort_out_y", out_y, 0);
          chk("abort_out_diff", $signed(out_diff), 0);
          chk("abort_pc_in", pc_in, 0);
          chk("abort_in_ready", in_ready, 1);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
    end
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("out_valid_timeout", 0, 1);
    if (exp_lat >= 0 && !gaps) chk("latency", cyc - c0, exp_lat);
    chk("out_diff", $signed(out_diff), exp_diff);
    chk("out_y", out_y, exp_y);
    chk("in_ready_in_out", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_diff", $signed(out_diff), exp_diff);
      chk("hold_y", out_y, exp_y);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_accept", out_valid, 0);
    chk("ready_after_accept", in_ready, 1);
  endtask

  initial begin
    int d, lat;
    logic [1:0] y;
    bit g, seen;
    logic [23:0] w;

    vt[0] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 10, -10, 1'b0, 96, 2'b01, LAT_W0};
    vt[1] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 10, -10, 1'b0, -96, 2'b11, 12};
    vt[2] = '{24'h00000F, 24'h000003, 24'h00000C, 1, -1, 1'b0, 0, 2'b00, 12};
    vt[3] = '{24'h00000F, 24'h000003, 24'h00000C, 0, -1, 1'b0, 0, 2'b01, 12};
    vt[4] = '{24'h000001, 24'h000001, 24'h000000, 10, -10, 1'b1, 96, 2'b01, LAT_W0};
    vt[5] = '{24'h00000F, 24'h000003, 24'h00000C, -5, 5, 1'b0, 0, 2'b01, 12};
    vt[6] = '{24'hFFFFFF, 24'h000000, 24'h000001, 10, -4, 1'b0, -4, 2'b11, 12};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pc_in", pc_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_diff", $signed(out_diff), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < CH; k++) begin
        cx[k] = vt[i].x;
        cwp[k] = vt[i].wp;
        cwn[k] = vt[i].wn;
      end
      f31 = vt[i].f31;
      run_eval(vt[i].hi, vt[i].lo, 1'b0, -1, (i == 0) ? 5 : 1, vt[i].diff, vt[i].y, vt[i].lat);
    end
    f31 = 1'b0;

    for (int k = 0; k < CH; k++) begin
      cx[k] = 24'hFFFFFF;
      cwp[k] = 24'h00FFFF;
      cwn[k] = 24'hFF0000;
    end
    run_eval(10, -10, 1'b0, 2, 0, 0, 2'b00, -1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_valid_after_abort", seen, 0);
    model(10, -10, d, y);
    run_eval(10, -10, 1'b0, -1, 0, d, y, 12);

    for (int r = 0; r < 16; r++) begin
      int hi, lo;
      lat = 0;
      for (int k = 0; k < CH; k++) begin
        cx[k] = 24'($urandom);
        cwp[k] = 24'($urandom);
        w = 24'($urandom);
        cwn[k] = (r % 4 == 0) ? 24'd0 : (w & ~cwp[k]);
        if ((cwp[k] & cwn[k]) != 24'd0) $display("bad stimulus: overlapping weight masks");
        lat += (SKIP && ((cx[k] & cwn[k]) == 24'd0)) ? 2 : 3;
      end
      hi = int'($urandom_range(0, 120)) - 60;
      lo = int'($urandom_range(0, 120)) - 60;
      g = (r % 3 == 1);
      model(hi, lo, d, y);
      run_eval(hi, lo, g, -1, $urandom_range(0, 3), d, y, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
